sd_bd_queue: RTL and testbench

SD_BD_QUEUE -- requirements
Module: sd_bd_queue

---
 rtl/sd_bd_queue.sv | 186 ++++++++++++++++++
 tb/tb_sd_bd_queue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_bd_queue.sv
// sd_bd_queue -- buffer-descriptor queue between a host writer and a DMA-style
// reader. Each descriptor is two 32-bit words (sys_adr, cmd_arg) written by the
// host in two separate handshakes. A descriptor becomes visible to the reader
// only once both words are in. Reading the head does not remove it; the entry
// is released only by a_cmp when its transfer completes.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   we_m, dat_in_m  host write request / word (sys_adr then cmd_arg), held until we_ack
//   we_ack          one-cycle pulse: host word accepted
//   re_s            reader request for the head descriptor, held until ack_o_s
//   ack_o_s         one-cycle pulse: dat_out/arg_out hold the head descriptor
//   dat_out,arg_out head sys_adr / cmd_arg, held until the next read
//   a_cmp           one-cycle pulse: head transfer complete, release the slot
//   bd_clr          synchronous flush of all entries and the write phase
//   free_bd         free slot count (DEPTH = empty, 0 = full)
module sd_bd_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_m,
   input  logic [31:0]   dat_in_m,
   output logic          we_ack,
   input  logic          re_s,
   output logic          ack_o_s,
   output logic [31:0]   dat_out,
   output logic [31:0]   arg_out,
   input  logic          a_cmp,
   input  logic          bd_clr,
   output logic [AW:0]   free_bd
);

   localparam logic [AW:0] FREE_ALL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {W_ADR, W_ARG, W_WAIT} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} r_state_t;

   logic [31:0] adr_mem [DEPTH];
   logic [31:0] arg_mem [DEPTH];

   w_state_t    w_state_q, w_state_d;
   w_state_t    w_ret_q, w_ret_d;
   r_state_t    r_state_q, r_state_d;
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0] free_q, free_d;
   logic        we_ack_q, we_ack_d;
   logic        ack_q, ack_d;
   logic [31:0] dat_out_q, arg_out_q;

   logic adr_we, arg_we, commit, pop, rd_load;
   logic full, empty;

   assign full  = (free_q == '0);
   assign empty = (free_q == FREE_ALL);

   always_comb begin
      w_state_d = w_state_q;
      w_ret_d   = w_ret_q;
      r_state_d = r_state_q;
      we_ack_d  = 1'b0;
      ack_d     = 1'b0;
      adr_we    = 1'b0;
      arg_we    = 1'b0;
      commit    = 1'b0;
      rd_load   = 1'b0;

      // Write side: W_WAIT holds off until the host drops we_m so a single
      // held request can never be acknowledged twice.
      case (w_state_q)
         W_ADR: begin
            if (we_m && !full) begin
               adr_we    = 1'b1;
               we_ack_d  = 1'b1;
               w_state_d = W_WAIT;
               w_ret_d   = W_ARG;
            end
         end
         W_ARG: begin
            // A slot was reserved when sys_adr was accepted, so no full check.
            if (we_m) begin
               arg_we    = 1'b1;
               we_ack_d  = 1'b1;
               commit    = 1'b1;
               w_state_d = W_WAIT;
               w_ret_d   = W_ADR;
            end
         end
         W_WAIT: begin
            if (!we_m) w_state_d = w_ret_q;
         end
         default: w_state_d = W_ADR;
      endcase

      // Read side: data registered in R_IDLE, ack registered out of R_ACK,
      // giving two cycles from request to ack.
      case (r_state_q)
         R_IDLE: begin
            if (re_s && !empty) begin
               rd_load   = 1'b1;
               r_state_d = R_ACK;
            end
         end
         R_ACK: begin
            ack_d     = 1'b1;
            r_state_d = R_WAIT;
         end
         R_WAIT: begin
            if (!re_s) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase

      pop  = a_cmp && !empty;
      wp_d = wp_q + AW'(commit);
      rp_d = rp_q + AW'(pop);
      case ({commit, pop})
         2'b10:   free_d = free_q - 1'b1;
         2'b01:   free_d = free_q + 1'b1;
         default: free_d = free_q;
      endcase

      // Flush overrides everything happening in the same cycle.
      if (bd_clr) begin
         w_state_d = W_ADR;
         w_ret_d   = W_ADR;
         r_state_d = R_IDLE;
         we_ack_d  = 1'b0;
         ack_d     = 1'b0;
         adr_we    = 1'b0;
         arg_we    = 1'b0;
         rd_load   = 1'b0;
         wp_d      = '0;
         rp_d      = '0;
         free_d    = FREE_ALL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_ADR;
         w_ret_q   <= W_ADR;
         r_state_q <= R_IDLE;
         wp_q      <= '0;
         rp_q      <= '0;
         free_q    <= FREE_ALL;
         we_ack_q  <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_ret_q   <= w_ret_d;
         r_state_q <= r_state_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         free_q    <= free_d;
         we_ack_q  <= we_ack_d;
         ack_q     <= ack_d;
      end
   end

   // Descriptor storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (adr_we) adr_mem[wp_q] <= dat_in_m;
      if (arg_we) arg_mem[wp_q] <= dat_in_m;
   end

   // Registered head read; holds until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat_out_q <= '0;
         arg_out_q <= '0;
      end else if (rd_load) begin
         dat_out_q <= adr_mem[rp_q];
         arg_out_q <= arg_mem[rp_q];
      end
   end

   assign we_ack  = we_ack_q;
   assign ack_o_s = ack_q;
   assign dat_out = dat_out_q;
   assign arg_out = arg_out_q;
   assign free_bd = free_q;

endmodule

// File: tb/tb_sd_bd_queue.sv
module tb_sd_bd_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          we_m = 1'b0;
   logic [31:0]   dat_in_m = '0;
   logic          we_ack;
   logic          re_s = 1'b0;
   logic          ack_o_s;
   logic [31:0]   dat_out, arg_out;
   logic          a_cmp = 1'b0;
   logic          bd_clr = 1'b0;
   logic [AW:0]   free_bd;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: committed descriptors in FIFO order.
   logic [31:0] q_adr[$];
   logic [31:0] q_arg[$];

   always #5 clk = ~clk;

   sd_bd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .we_m(we_m), .dat_in_m(dat_in_m), .we_ack(we_ack),
      .re_s(re_s), .ack_o_s(ack_o_s), .dat_out(dat_out), .arg_out(arg_out),
      .a_cmp(a_cmp), .bd_clr(bd_clr), .free_bd(free_bd)
   );

   function automatic logic [AW:0] exp_free();
      return (AW+1)'(DEPTH - q_adr.size());
   endfunction

   // One host word: raise we_m, wait for the ack, drop, confirm no extra ack.
   task automatic host_write(input logic [31:0] w, input bit with_cmp);
      int lat = 0;
      int extra = 0;
      @(negedge clk);
      we_m = 1'b1; dat_in_m = w;
      if (with_cmp) a_cmp = 1'b1;
      while (lat < 20) begin
         @(negedge clk);
         a_cmp = 1'b0;
         lat++;
         if (we_ack) break;
      end
      we_m = 1'b0;
      vectors++;
      if (we_ack !== 1'b1 || lat != 1) begin
         miscompares++;
         $display("FAIL wr_ack: word %h ack=%b after %0d cycles, required ack=1 after 1", w, we_ack, lat);
      end
      repeat (3) begin
         @(negedge clk);
         if (we_ack) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL wr_single_ack: word %h extra acks=%0d, required 0", w, extra);
      end
      $display("write %h lat=%0d free_bd=%0d", w, lat, free_bd);
   endtask

   task automatic write_entry(input logic [31:0] a, input logic [31:0] g, input bit with_cmp);
      bit had_entry;
      host_write(a, 1'b0);
      vectors++;
      if (free_bd !== exp_free()) begin
         miscompares++;
         $display("FAIL free_half_entry: free_bd=%0d, required %0d", free_bd, exp_free());
      end
      had_entry = (q_adr.size() != 0);
      host_write(g, with_cmp);
      q_adr.push_back(a); q_arg.push_back(g);
      if (with_cmp && had_entry) begin
         void'(q_adr.pop_front()); void'(q_arg.pop_front());
      end
      vectors++;
      if (free_bd !== exp_free()) begin
         miscompares++;
         $display("FAIL free_commit: free_bd=%0d, required %0d", free_bd, exp_free());
      end
   endtask

   task automatic host_read(input int hold, output logic [31:0] a, output logic [31:0] g);
      int lat = 0;
      int extra = 0;
      @(negedge clk);
      re_s = 1'b1;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (ack_o_s) break;
      end
      vectors++;
      if (ack_o_s !== 1'b1 || lat != 2) begin
         miscompares++;
         $display("FAIL rd_ack: ack_o_s=%b after %0d cycles, required 1 after 2", ack_o_s, lat);
      end
      a = dat_out; g = arg_out;
      repeat (hold) begin
         @(negedge clk);
         if (ack_o_s) extra++;
      end
      re_s = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ack_o_s) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL rd_single_ack: extra acks=%0d, required 0", extra);
      end
      $display("read adr=%h arg=%h lat=%0d", a, g, lat);
   endtask

   task automatic pulse_cmp();
      @(negedge clk);
      a_cmp = 1'b1;
      @(negedge clk);
      a_cmp = 1'b0;
      if (q_adr.size() != 0) begin
         void'(q_adr.pop_front()); void'(q_arg.pop_front());
      end
      vectors++;
      if (free_bd !== exp_free()) begin
         miscompares++;
         $display("FAIL free_pop: free_bd=%0d, required %0d", free_bd, exp_free());
      end
      $display("a_cmp free_bd=%0d", free_bd);
   endtask

   task automatic read_check_pop(input int hold);
      logic [31:0] a, g;
      host_read(hold, a, g);
      vectors++;
      if (a !== q_adr[0] || g !== q_arg[0]) begin
         miscompares++;
         $display("FAIL head_data: got %h/%h, required %h/%h", a, g, q_adr[0], q_arg[0]);
      end
      pulse_cmp();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (we_ack !== 1'b0 || ack_o_s !== 1'b0 || dat_out !== 32'h0 ||
          arg_out !== 32'h0 || free_bd !== 3'd4) begin
         miscompares++;
         $display("FAIL reset: we_ack=%b ack=%b dat=%h arg=%h free=%0d, required 0 0 0 0 4",
                  we_ack, ack_o_s, dat_out, arg_out, free_bd);
      end
      $display("reset free_bd=%0d", free_bd);
   endtask

   task automatic test_basic();
      logic [31:0] a, g;
      write_entry(32'h1000_0000, 32'h0000_0200, 1'b0);
      host_read(0, a, g);
      vectors++;
      if (a !== 32'h1000_0000 || g !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL basic_data: got %h/%h, required 10000000/00000200", a, g);
      end
      pulse_cmp();
   endtask

   task automatic test_full();
      int acks = 0;
      int lat = 0;
      logic [31:0] stall_adr = $urandom;
      logic [31:0] stall_arg = $urandom;
      for (int i = 0; i < DEPTH; i++) write_entry($urandom, $urandom, 1'b0);
      @(negedge clk);
      we_m = 1'b1; dat_in_m = stall_adr;
      repeat (10) begin
         @(negedge clk);
         if (we_ack) acks++;
      end
      vectors++;
      if (acks != 0 || free_bd !== 3'd0) begin
         miscompares++;
         $display("FAIL full_stall: acks=%0d free=%0d, required 0 0", acks, free_bd);
      end
      a_cmp = 1'b1;
      void'(q_adr.pop_front()); void'(q_arg.pop_front());
      @(negedge clk);
      a_cmp = 1'b0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (we_ack) break;
      end
      we_m = 1'b0;
      vectors++;
      if (we_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL full_release_ack: we_ack=%b, required 1", we_ack);
      end
      repeat (2) @(negedge clk);
      host_write(stall_arg, 1'b0);
      q_adr.push_back(stall_adr); q_arg.push_back(stall_arg);
      vectors++;
      if (free_bd !== 3'd0) begin
         miscompares++;
         $display("FAIL full_after_fifth: free_bd=%0d, required 0", free_bd);
      end
      while (q_adr.size() != 0) read_check_pop(0);
   endtask

   task automatic test_empty_read();
      int acks = 0;
      @(negedge clk);
      re_s = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (ack_o_s) acks++;
      end
      re_s = 1'b0;
      vectors++;
      if (acks != 0) begin
         miscompares++;
         $display("FAIL empty_read: acks=%0d, required 0", acks);
      end
      pulse_cmp();
      vectors++;
      if (free_bd !== 3'd4) begin
         miscompares++;
         $display("FAIL empty_cmp: free_bd=%0d, required 4", free_bd);
      end
   endtask

   task automatic test_hold_read();
      logic [31:0] a, g;
      write_entry($urandom, $urandom, 1'b0);
      write_entry($urandom, $urandom, 1'b0);
      host_read(5, a, g);
      vectors++;
      if (a !== q_adr[0] || g !== q_arg[0]) begin
         miscompares++;
         $display("FAIL hold_first: got %h/%h, required %h/%h", a, g, q_adr[0], q_arg[0]);
      end
      read_check_pop(0);
      read_check_pop(3);
   endtask

   task automatic test_back_to_back();
      int written = 0;
      int iter = 0;
      write_entry($urandom, $urandom, 1'b0);
      write_entry($urandom, $urandom, 1'b0);
      write_entry($urandom, $urandom, 1'b1);
      vectors++;
      if (free_bd !== 3'd2) begin
         miscompares++;
         $display("FAIL commit_and_cmp: free_bd=%0d, required 2", free_bd);
      end
      while (written < 6 * DEPTH && iter < 200) begin
         iter++;
         if (q_adr.size() < DEPTH && (q_adr.size() == 0 || $urandom_range(1, 0) == 1)) begin
            write_entry($urandom, $urandom, 1'b0);
            written++;
         end else begin
            read_check_pop($urandom_range(2, 0));
         end
      end
      while (q_adr.size() != 0) read_check_pop(0);
   endtask

   task automatic test_abandon(input bit use_clr);
      logic [31:0] a, g;
      logic [31:0] ea = $urandom;
      logic [31:0] eg = $urandom;
      host_write(32'hDEAD_0000 | 32'($urandom_range(255, 0)), 1'b0);
      @(negedge clk);
      if (use_clr) bd_clr = 1'b1; else rst = 1'b1;
      @(negedge clk);
      bd_clr = 1'b0; rst = 1'b0;
      q_adr.delete(); q_arg.delete();
      vectors++;
      if (free_bd !== 3'd4) begin
         miscompares++;
         $display("FAIL abandon_free(clr=%0d): free_bd=%0d, required 4", use_clr, free_bd);
      end
      write_entry(ea, eg, 1'b0);
      host_read(0, a, g);
      vectors++;
      if (a !== ea || g !== eg) begin
         miscompares++;
         $display("FAIL abandon_data(clr=%0d): got %h/%h, required %h/%h", use_clr, a, g, ea, eg);
      end
      pulse_cmp();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_empty_read();
      test_hold_read();
      test_back_to_back();
      test_abandon(1'b0);
      test_abandon(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end
endmodule
